// File: rtl/stage_if_fetch.sv
// Instruction fetch stage: one outstanding instruction-memory request, a single
// holding register toward decode, and redirect handling with wrong-path discard.
module stage_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    input  logic        Feedback_Mem_Acc,
    output logic [31:0] Inst,
    output logic [31:0] PC_O,
    output logic        Done_O,
    output logic [31:0] Fetch_Cnt
);

    typedef enum logic [3:0] {
        S_INIT = 4'b0001,
        S_IF   = 4'b0010,
        S_IW   = 4'b0100,
        S_HOLD = 4'b1000
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] inst_r;
    logic [31:0] inst_s;
    logic [31:0] pc_o_r;
    logic [31:0] pc_o_s;
    logic        done_r;
    logic        done_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_s;
    logic        kill_r;
    logic        kill_s;
    logic        req_valid_r;
    logic        inst_ready_r;
    logic        req_hs_s;
    logic        resp_hs_s;
    logic [31:0] target_s;

    assign target_s  = {Redirect_PC[31:2], 2'b00};
    assign req_hs_s  = req_valid_r & Inst_Req_Ready;
    assign resp_hs_s = inst_ready_r & Inst_Valid;

    // Next-state and datapath update; a redirect always wins over sequential PC+4.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        pc_o_s  = pc_o_r;
        done_s  = done_r;
        cnt_s   = cnt_r;
        kill_s  = kill_r;
        case (state_r)
            S_INIT: begin
                state_s = S_IF;
                if (Redirect_Valid) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_IF: begin
                if (Redirect_Valid) begin
                    pc_s = target_s;
                end else if (req_hs_s) begin
                    state_s = S_IW;
                end else begin
                    state_s = S_IF;
                end
            end
            S_IW: begin
                if (Redirect_Valid) begin
                    pc_s = target_s;
                    if (resp_hs_s) begin
                        // The in-flight response is wrong-path; drop it right away.
                        state_s = S_IF;
                        kill_s  = 1'b0;
                    end else begin
                        kill_s  = 1'b1;
                    end
                end else if (resp_hs_s) begin
                    if (kill_r) begin
                        state_s = S_IF;
                        kill_s  = 1'b0;
                    end else begin
                        state_s = S_HOLD;
                        inst_s  = Instruction;
                        pc_o_s  = pc_r;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = S_IW;
                end
            end
            S_HOLD: begin
                if (Redirect_Valid) begin
                    state_s = S_IF;
                    pc_s    = target_s;
                    done_s  = 1'b0;
                end else if (!Feedback_Mem_Acc) begin
                    state_s = S_IF;
                    pc_s    = pc_r + 32'd4;
                    cnt_s   = cnt_r + 32'd1;
                    done_s  = 1'b0;
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_INIT;
                done_s  = 1'b0;
                kill_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; handshake strobes are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_INIT;
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            pc_o_r       <= 32'h0000_0000;
            done_r       <= 1'b0;
            cnt_r        <= 32'h0000_0000;
            kill_r       <= 1'b0;
            req_valid_r  <= 1'b0;
            inst_ready_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            pc_o_r       <= pc_o_s;
            done_r       <= done_s;
            cnt_r        <= cnt_s;
            kill_r       <= kill_s;
            req_valid_r  <= (state_s == S_IF);
            inst_ready_r <= (state_s == S_IW);
        end
    end

    assign PC             = pc_r;
    assign Inst_Req_Valid = req_valid_r;
    assign Inst_Ready     = inst_ready_r;
    assign Inst           = inst_r;
    assign PC_O           = pc_o_r;
    assign Done_O         = done_r;
    assign Fetch_Cnt      = cnt_r;

    stage_if_fetch_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .state         (state_r),
        .done          (done_r),
        .req_valid     (req_valid_r),
        .inst_ready    (inst_ready_r),
        .redirect_valid(Redirect_Valid),
        .redirect_low  (Redirect_PC[1:0])
    );

endmodule

// Structural invariants of the fetch stage control.
module stage_if_fetch_chk (
    input logic       clk,
    input logic       rst,
    input logic [3:0] state,
    input logic       done,
    input logic       req_valid,
    input logic       inst_ready,
    input logic       redirect_valid,
    input logic [1:0] redirect_low
);

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state));
    a_done_hold: assert property (@(posedge clk) disable iff (rst) done |-> (state == 4'b1000));
    a_req_if: assert property (@(posedge clk) disable iff (rst) req_valid == (state == 4'b0010));
    a_rdy_iw: assert property (@(posedge clk) disable iff (rst) inst_ready == (state == 4'b0100));
    c_misaligned: cover property (@(posedge clk) redirect_valid && (redirect_low != 2'b00));

endmodule

// File: tb/tb_stage_if_fetch.sv
// Scoreboard bench for stage_if_fetch: a small memory responder, a consumption
// monitor popping expected (PC, instruction) pairs, and directed scenarios.
module tb_stage_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        Feedback_Mem_Acc;
    logic [31:0] Inst;
    logic [31:0] PC_O;
    logic        Done_O;
    logic [31:0] Fetch_Cnt;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          resp_delay = 1;
    logic [31:0] last_hs_addr = 32'h0;
    int          hs_count = 0;
    int          hs_snap;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    int          cons_cyc[$];

    stage_if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_PC     (Redirect_PC),
        .Feedback_Mem_Acc(Feedback_Mem_Acc),
        .Inst            (Inst),
        .PC_O            (PC_O),
        .Done_O          (Done_O),
        .Fetch_Cnt       (Fetch_Cnt)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(mem_word(pc));
    endtask

    task automatic wait_cnt(input logic [31:0] v, input int maxc);
        int n = 0;
        while (Fetch_Cnt != v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_fetch_cnt", Fetch_Cnt, v);
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!Done_O && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {31'h0, Done_O}, 32'h1);
    endtask

    // Memory responder: drives response at negedge, samples handshakes 2 units later.
    initial begin
        logic        pend = 1'b0;
        logic        resp_hs = 1'b0;
        logic [31:0] paddr = 32'h0;
        int          cnt = 0;
        Inst_Valid  = 1'b0;
        Instruction = 32'h0;
        forever begin
            @(negedge clk);
            if (resp_hs) Inst_Valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    Inst_Valid  = 1'b1;
                    Instruction = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            #2;
            resp_hs = Inst_Valid && Inst_Ready;
            if (rst) begin
                pend    = 1'b0;
                resp_hs = 1'b1;
            end else if (Inst_Req_Valid && Inst_Req_Ready) begin
                pend         = 1'b1;
                paddr        = PC;
                cnt          = resp_delay;
                last_hs_addr = PC;
                hs_count++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever decode consumes the held instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && Done_O && !Feedback_Mem_Acc && !Redirect_Valid) begin
                cons_cyc.push_back(cyc);
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h with empty queue", PC_O);
                end else begin
                    check("sb_pc", PC_O, exp_pc_q.pop_front());
                    check("sb_inst", Inst, exp_inst_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        Inst_Req_Ready   = 1'b1;
        Redirect_Valid   = 1'b0;
        Redirect_PC      = 32'h0;
        Feedback_Mem_Acc = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", PC, 32'h0);
        check("rst_done", {31'h0, Done_O}, 32'h0);
        check("rst_req_valid", {31'h0, Inst_Req_Valid}, 32'h0);
        check("rst_inst_ready", {31'h0, Inst_Ready}, 32'h0);
        check("rst_cnt", Fetch_Cnt, 32'h0);
        check("rst_inst", Inst, 32'h0);
        check("rst_pc_o", PC_O, 32'h0);

        // Sequential fetch of 0, 4, 8 at minimum latency
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        rst = 1'b0;
        wait_cnt(32'd3, 40);
        if (cons_cyc.size() >= 3) begin
            check("spacing_0_1", cons_cyc[1] - cons_cyc[0], 32'd3);
            check("spacing_1_2", cons_cyc[2] - cons_cyc[1], 32'd3);
        end else begin
            check("consume_count", cons_cyc.size(), 32'd3);
        end

        // Downstream stall while holding PC 12
        Feedback_Mem_Acc = 1'b1;
        wait_done(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_done", {31'h0, Done_O}, 32'h1);
            check("stall_pc_o", PC_O, 32'hC);
            check("stall_inst", Inst, mem_word(32'hC));
            check("stall_no_req", {31'h0, Inst_Req_Valid}, 32'h0);
            @(negedge clk);
        end
        check("stall_cnt", Fetch_Cnt, 32'd3);
        push_exp(32'hC);
        Feedback_Mem_Acc = 1'b0;
        resp_delay = 2;
        @(negedge clk);
        check("release_pc", PC, 32'h10);
        check("release_req", {31'h0, Inst_Req_Valid}, 32'h1);
        check("release_cnt", Fetch_Cnt, 32'd4);

        // Redirect while waiting for the response of PC 16
        @(negedge clk);
        check("iw_ready", {31'h0, Inst_Ready}, 32'h1);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h100;
        @(negedge clk);
        Redirect_Valid   = 1'b0;
        Feedback_Mem_Acc = 1'b1;
        check("kill_done0", {31'h0, Done_O}, 32'h0);
        @(negedge clk);
        check("kill_done1", {31'h0, Done_O}, 32'h0);
        check("kill_next_pc", PC, 32'h100);
        check("kill_req", {31'h0, Inst_Req_Valid}, 32'h1);
        wait_done(20);
        check("redir_pc_o", PC_O, 32'h100);
        check("redir_inst", Inst, mem_word(32'h100));
        check("redir_hs_addr", last_hs_addr, 32'h100);

        // Redirect in HOLD with decode ready the same cycle
        Feedback_Mem_Acc = 1'b0;
        Redirect_Valid   = 1'b1;
        Redirect_PC      = 32'h203;
        @(negedge clk);
        Redirect_Valid = 1'b0;
        check("hold_redir_done", {31'h0, Done_O}, 32'h0);
        check("hold_redir_cnt", Fetch_Cnt, 32'd4);
        check("hold_redir_pc", PC, 32'h200);
        check("hold_redir_req", {31'h0, Inst_Req_Valid}, 32'h1);

        // Memory not ready for 4 cycles, redirect to 0x40 in the middle
        Inst_Req_Ready = 1'b0;
        hs_snap = hs_count;
        @(negedge clk);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h40;
        @(negedge clk);
        Redirect_Valid = 1'b0;
        check("stall_redir_pc", PC, 32'h40);
        check("stall_redir_req", {31'h0, Inst_Req_Valid}, 32'h1);
        repeat (2) @(negedge clk);
        Inst_Req_Ready = 1'b1;
        resp_delay = 1;
        push_exp(32'h40);
        wait_cnt(32'd5, 30);
        check("stall_hs_addr", last_hs_addr, 32'h40);
        check("stall_hs_count", hs_count - hs_snap, 32'd1);
        check("seq_after_40", PC, 32'h44);

        // Wrap of PC+4 from the top of the address space
        Inst_Req_Ready = 1'b0;
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'hFFFF_FFFE;
        @(negedge clk);
        Redirect_Valid = 1'b0;
        check("top_pc", PC, 32'hFFFF_FFFC);
        Inst_Req_Ready = 1'b1;
        push_exp(32'hFFFF_FFFC);
        wait_cnt(32'd6, 30);
        check("wrap_pc", PC, 32'h0);
        check("wrap_req", {31'h0, Inst_Req_Valid}, 32'h1);
        Feedback_Mem_Acc = 1'b1;
        wait_done(20);
        check("wrap_pc_o", PC_O, 32'h0);
        check("wrap_inst", Inst, mem_word(32'h0));
        check("wrap_cnt", Fetch_Cnt, 32'd6);

        // Reset from HOLD
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_done", {31'h0, Done_O}, 32'h0);
        check("rst2_cnt", Fetch_Cnt, 32'h0);
        check("rst2_pc", PC, 32'h0);
        check("rst2_inst_ready", {31'h0, Inst_Ready}, 32'h0);
        check("rst2_inst", Inst, 32'h0);
        check("sb_empty", exp_pc_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
